// File: rtl/mac_pkg.sv
// Shared types and the saturating-add helper for the accumulate half of the MAC path.
// The helper runs at a fixed wide width; callers zero-extend their operands and pass in the accumulator width.
package mac_pkg;

  localparam int DEF_PROD_W  = 16;
  localparam int DEF_ACC_W   = 24;
  localparam int DEF_COUNT_W = 4;
  localparam int SAT_MAX_W   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  typedef struct packed {
    logic                 clamp;
    logic [SAT_MAX_W-1:0] sum;
  } sat_res_t;

  // Both operands must already fit in acc_w bits, so "above the limit" is the carry-out.
  function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] a,
                                       input logic [SAT_MAX_W-1:0] b,
                                       input int                   acc_w);
    logic [SAT_MAX_W:0] full;
    logic [SAT_MAX_W:0] lim;
    sat_res_t           r;
    full    = {1'b0, a} + {1'b0, b};
    lim     = ({{SAT_MAX_W{1'b0}}, 1'b1} << acc_w) - (SAT_MAX_W + 1)'(1);
    r.clamp = (full > lim);
    r.sum   = r.clamp ? lim[SAT_MAX_W-1:0] : full[SAT_MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational unsigned saturating adder: ACC_W accumulator plus PROD_W addend, clamped to 2^ACC_W-1.
// Zero latency, no handshake.
module sat_adder
  import mac_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int PROD_W = DEF_PROD_W
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              clamp
);

  sat_res_t res;

  always_comb begin
    res   = sat_add(SAT_MAX_W'(a), SAT_MAX_W'(b), ACC_W);
    sum   = res.sum[ACC_W-1:0];
    clamp = res.clamp;
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a block of 1..2^COUNT_W products with saturation; result registered 1 cycle after the last beat.
// Holds the result under out_ready backpressure with in_ready low, costing one bubble per block.
module product_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W  = DEF_PROD_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PROD_W-1:0]  in_product,
  input  logic [COUNT_W-1:0] block_len,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [COUNT_W:0]   out_count,
  output logic               out_sat
);

  localparam int             CNT_W    = COUNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(1) << COUNT_W;

  acc_state_e       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_sat_q, out_sat_d;

  logic             beat;
  logic             go_hold;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_sum;
  logic             add_clamp;

  assign in_ready = (state_q != HOLD) && !reset;
  assign beat     = in_valid && in_ready;

  // The first beat of a block adds onto zero, so one adder serves both IDLE and ACCUM.
  assign add_a = (state_q == ACCUM) ? acc_q : '0;

  sat_adder #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_adder (
    .a     (add_a),
    .b     (in_product),
    .sum   (add_sum),
    .clamp (add_clamp)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    go_hold     = 1'b0;

    case (state_q)
      IDLE: begin
        if (beat) begin
          len_d   = (block_len == '0) ? FULL_LEN : {1'b0, block_len};
          acc_d   = add_sum;
          cnt_d   = CNT_ONE;
          sat_d   = 1'b0;
          state_d = ACCUM;
          go_hold = (len_d == CNT_ONE) || flush;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d   = add_sum;
          cnt_d   = cnt_q + CNT_ONE;
          sat_d   = sat_q | add_clamp;
          go_hold = (cnt_d == len_q) || flush;
        end else begin
          go_hold = flush;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Output registers load only when a block closes, so they stay stable through HOLD.
    if (go_hold) begin
      state_d     = HOLD;
      out_valid_d = 1'b1;
      out_sum_d   = acc_d;
      out_count_d = cnt_d;
      out_sat_d   = sat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 8x8 multiplier's 16-bit product.
- Accumulates a block of 1..2^COUNT_W products into a saturating sum, then presents the result on a valid/ready output handshake.
- Forms the accumulate half of a MAC path: the multiplier's product goes into in_product, and the accumulated sum goes to the downstream consumer.
- One clock domain. Synchronous, active-high reset.

Parameters:
- PROD_W, 16, width of incoming product (2x multiplier operand width).
- ACC_W, 24, accumulator and output sum width; must be >= PROD_W.
- COUNT_W, 4, block-length field width; the maximum block is 2^COUNT_W terms.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_product is valid this cycle.
- in_ready  output  1  block can accept a product this cycle.
- in_product  input  PROD_W  unsigned product from the multiplier.
- block_len  input  COUNT_W  number of terms in a block; 0 encodes 2^COUNT_W; sampled only on the first beat of a block.
- flush  input  1  close the current block early.
- out_valid  output  1  result is held and valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  saturated unsigned sum of the block.
- out_count  output  COUNT_W+1  number of terms actually accumulated.
- out_sat  output  1  at least one addition in the block clamped.

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high (reset).
- Handshake:
  - Input beat transfers when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
- FSM states: IDLE, ACCUM, HOLD.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. in_ready is forced to 0 while reset is high.
- IDLE:
  - On beat: len_q = (block_len==0 ? 2^COUNT_W : block_len); acc = zero-extended in_product; cnt = 1; sat_q = 0.
  - If len_q == 1, or flush is high the same cycle: go to HOLD. Otherwise go to ACCUM.
  - flush without a beat is ignored.
- ACCUM:
  - On beat: acc = sat_add(acc, in_product); cnt++; sat_q |= clamp.
  - Go to HOLD when the new cnt == len_q, or when flush is high.
  - flush with no beat: go to HOLD with the current acc and cnt. The block always holds at least 1 term.
  - flush together with a beat: the beat is included first, then HOLD.
- HOLD:
  - out_valid = 1. out_sum = acc, out_count = cnt, out_sat = sat_q, all stable until the transfer.
  - On out_ready: go to IDLE and drop out_valid the next cycle.
  - No input accepted in HOLD. This costs one bubble per block, so throughput is len+1 cycles per block plus any backpressure.
  - flush is ignored in HOLD.
- Arithmetic:
  - Unsigned add at ACC_W+1 bits; if the carry-out is set, the result is clamped to 2^ACC_W-1 and clamp = 1.
  - With the defaults, 16 x 65025 = 1,040,400 < 2^24, so no saturation occurs. Saturation is reachable only with a reduced ACC_W.
- Output registers: out_sum, out_count and out_sat are registered (no combinational path from input to output). Latency from the last accepted beat to out_valid is 1 cycle.
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - Reset mid-block or in HOLD discards the partial or held result without producing an output transfer.
  - in_ready rises in the first cycle after reset deasserts.
- Inputs are don't-care when the matching valid or ready signal is low. block_len changes mid-block have no effect.

Decomposition:
- Shared package (mac_pkg):
  - FSM state enum: IDLE, ACCUM, HOLD.
  - Default constants: PROD_W, ACC_W, COUNT_W.
  - sat_add function, returning the sum and the clamp bit.
- One sub-module, sat_adder: combinational, parameterised ACC_W/PROD_W, outputs sum and clamp. It is reusable by a later signed or MAC variant.
- FSM, counters and output registers live in product_accumulator.

Test Plan:
- Basic block: block_len=4; products 65025, 1, 2, 3 on back-to-back beats with out_ready=1 -> one cycle after the 4th beat: out_valid=1, out_sum=65031, out_count=4, out_sat=0; in_ready=0 while out_valid is high.
- Full-length block: block_len=0; 16 beats of 65025 -> out_sum=1040400 (0xFE010), out_count=16, out_sat=0.
- Saturation (ACC_W=17): block_len=3; beats of 65025 x3 -> out_sum=131071, out_count=3, out_sat=1. The next block of 1, 2 gives out_sat=0 and out_sum=3.
- Flush: block_len=8; beats 10, 20, 30 with flush high on the third beat -> out_sum=60, out_count=3. Flush in IDLE with no beat produces no output.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid held high -> out_valid, out_sum and out_count stay stable and in_ready=0. Raise out_ready -> result transfers, in_ready=1 the next cycle, and the next block starts cleanly.
- Reset mid-block: 2 beats of 100, then reset for 1 cycle -> no output ever appears. The next block_len=1 beat of 7 gives out_sum=7, out_count=1.
